// File: rtl/mem_level.sv
// MEM pipeline stage: word-organised data memory with byte/half/word access and the MEM/WB register.
// Optional macro DM_WRITE_DISPLAY_EN traces every committed store.
package mem_level_pkg;
    localparam int WIDTH_INSTR = 6;
    localparam int WIDTH_T     = 3;

    localparam logic [WIDTH_INSTR-1:0] INSTR_NOP = 6'd0;
    localparam logic [WIDTH_INSTR-1:0] INSTR_ADD = 6'd1;
    localparam logic [WIDTH_INSTR-1:0] INSTR_LW  = 6'd2;
    localparam logic [WIDTH_INSTR-1:0] INSTR_LH  = 6'd3;
    localparam logic [WIDTH_INSTR-1:0] INSTR_LHU = 6'd4;
    localparam logic [WIDTH_INSTR-1:0] INSTR_LB  = 6'd5;
    localparam logic [WIDTH_INSTR-1:0] INSTR_LBU = 6'd6;
    localparam logic [WIDTH_INSTR-1:0] INSTR_SW  = 6'd7;
    localparam logic [WIDTH_INSTR-1:0] INSTR_SH  = 6'd8;
    localparam logic [WIDTH_INSTR-1:0] INSTR_SB  = 6'd9;

    localparam logic [1:0] FUNC_OTHER     = 2'd0;
    localparam logic [1:0] FUNC_MEM_READ  = 2'd1;
    localparam logic [1:0] FUNC_MEM_WRITE = 2'd2;

    function automatic logic [1:0] ic_func(input logic [WIDTH_INSTR-1:0] instr);
        case (instr)
            INSTR_LW, INSTR_LH, INSTR_LHU, INSTR_LB, INSTR_LBU: return FUNC_MEM_READ;
            INSTR_SW, INSTR_SH, INSTR_SB:                       return FUNC_MEM_WRITE;
            default:                                            return FUNC_OTHER;
        endcase
    endfunction
endpackage

module mem_level
    import mem_level_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int DM_AW    = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   clr,
    input  logic [WIDTH_INSTR-1:0] instr_MEM,
    input  logic [31:0]            PC_MEM,
    input  logic [31:0]            aluOut_MEM,
    input  logic [31:0]            memWriteData_MEM,
    input  logic [4:0]             addrRt_MEM,
    input  logic [4:0]             regWriteAddr_MEM,
    input  logic [31:0]            regWriteData_MEM,
    input  logic [WIDTH_T-1:0]     Tnew_MEM,
    input  logic [4:0]             regaddr_WB,
    input  logic [31:0]            regdata_WB,
    output logic [WIDTH_INSTR-1:0] instr_WB,
    output logic [31:0]            PC_WB,
    output logic [31:0]            memReadData_WB,
    output logic [4:0]             regWriteAddr_WB,
    output logic [31:0]            regWriteData_WB,
    output logic [WIDTH_T-1:0]     Tnew_WB
);
    logic [31:0] dm_q [DM_WORDS];

    logic [DM_AW-1:0]       idx;
    logic [1:0]             b;
    logic                   h;
    logic [1:0]             func;
    logic                   is_store;
    logic                   is_load;
    logic [31:0]            cur_word;
    logic [31:0]            st_data;
    logic [31:0]            merged_word;
    logic [7:0]             byte_v;
    logic [15:0]            half_v;
    logic [31:0]            ld_data;
    logic [31:0]            wd_next;
    logic [WIDTH_T-1:0]     tnew_next;

    logic [WIDTH_INSTR-1:0] instr_q, instr_d;
    logic [31:0]            pc_q, pc_d;
    logic [31:0]            rd_q, rd_d;
    logic [4:0]             wa_q, wa_d;
    logic [31:0]            wd_q, wd_d;
    logic [WIDTH_T-1:0]     tnew_q, tnew_d;

    // Upper address bits are deliberately dropped so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, aluOut_MEM[31:DM_AW+2]};

    always_comb begin
        func     = ic_func(instr_MEM);
        is_store = (func == FUNC_MEM_WRITE);
        is_load  = (func == FUNC_MEM_READ);
        idx      = aluOut_MEM[DM_AW+1:2];
        b        = aluOut_MEM[1:0];
        h        = aluOut_MEM[1];
        cur_word = dm_q[idx];

        // A WB-stage write to the store's rt is newer than the value captured at EX.
        st_data = ((regaddr_WB != 5'd0) && (regaddr_WB == addrRt_MEM)) ? regdata_WB
                                                                         : memWriteData_MEM;

        merged_word = cur_word;
        if (is_store) begin
            case (instr_MEM)
                INSTR_SW: merged_word = st_data;
                INSTR_SH: merged_word[{h, 4'b0000} +: 16] = st_data[15:0];
                INSTR_SB: merged_word[{b, 3'b000} +: 8]   = st_data[7:0];
                default:  merged_word = cur_word;
            endcase
        end

        byte_v  = cur_word[{b, 3'b000} +: 8];
        half_v  = cur_word[{h, 4'b0000} +: 16];
        ld_data = 32'd0;
        if (is_load) begin
            case (instr_MEM)
                INSTR_LW:  ld_data = cur_word;
                INSTR_LH:  ld_data = {{16{half_v[15]}}, half_v};
                INSTR_LHU: ld_data = {16'd0, half_v};
                INSTR_LB:  ld_data = {{24{byte_v[7]}}, byte_v};
                INSTR_LBU: ld_data = {24'd0, byte_v};
                default:   ld_data = 32'd0;
            endcase
        end

        wd_next   = is_load ? ld_data : regWriteData_MEM;
        tnew_next = (Tnew_MEM >= WIDTH_T'(1)) ? Tnew_MEM - WIDTH_T'(1) : '0;

        instr_d = instr_q;
        pc_d    = pc_q;
        rd_d    = rd_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        tnew_d  = tnew_q;
        if (reset || clr) begin
            instr_d = '0;
            pc_d    = '0;
            rd_d    = '0;
            wa_d    = '0;
            wd_d    = '0;
            tnew_d  = '0;
        end else if (!stall) begin
            instr_d = instr_MEM;
            pc_d    = PC_MEM;
            rd_d    = ld_data;
            wa_d    = regWriteAddr_MEM;
            wd_d    = wd_next;
            tnew_d  = tnew_next;
        end
    end

    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        pc_q    <= pc_d;
        rd_q    <= rd_d;
        wa_q    <= wa_d;
        wd_q    <= wd_d;
        tnew_q  <= tnew_d;
    end

    // The store commits even when clr squashes the MEM/WB register in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DM_WORDS; i++) dm_q[i] <= 32'd0;
        end else if (!stall && is_store) begin
            dm_q[idx] <= merged_word;
`ifdef DM_WRITE_DISPLAY_EN
            $display("@%h: *%h <= %h", PC_MEM, {aluOut_MEM[31:2], 2'b00}, merged_word);
`endif
        end
    end

    assign instr_WB        = instr_q;
    assign PC_WB           = pc_q;
    assign memReadData_WB  = rd_q;
    assign regWriteAddr_WB = wa_q;
    assign regWriteData_WB = wd_q;
    assign Tnew_WB         = tnew_q;
endmodule

// File: tb/tb_mem_level.sv
// Bench for mem_level: byte-array memory model, per-cycle output compare, directed plus random stimulus.
module tb_mem_level;
    import mem_level_pkg::*;

    bit clk;
    logic                   reset, stall, clr;
    logic [WIDTH_INSTR-1:0] instr_MEM;
    logic [31:0]            PC_MEM, aluOut_MEM, memWriteData_MEM, regWriteData_MEM, regdata_WB;
    logic [4:0]             addrRt_MEM, regWriteAddr_MEM, regaddr_WB;
    logic [WIDTH_T-1:0]     Tnew_MEM;
    logic [WIDTH_INSTR-1:0] instr_WB;
    logic [31:0]            PC_WB, memReadData_WB, regWriteData_WB;
    logic [4:0]             regWriteAddr_WB;
    logic [WIDTH_T-1:0]     Tnew_WB;

    mem_level #(.DM_WORDS(1024), .DM_AW(10)) dut (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr),
        .instr_MEM(instr_MEM), .PC_MEM(PC_MEM), .aluOut_MEM(aluOut_MEM),
        .memWriteData_MEM(memWriteData_MEM), .addrRt_MEM(addrRt_MEM),
        .regWriteAddr_MEM(regWriteAddr_MEM), .regWriteData_MEM(regWriteData_MEM),
        .Tnew_MEM(Tnew_MEM), .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB),
        .instr_WB(instr_WB), .PC_WB(PC_WB), .memReadData_WB(memReadData_WB),
        .regWriteAddr_WB(regWriteAddr_WB), .regWriteData_WB(regWriteData_WB),
        .Tnew_WB(Tnew_WB)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    logic [31:0] pc_ctr = 32'h0000_3000;

    // Reference: memory as 4096 little-endian bytes.
    logic [7:0]             mb [4096];
    logic [WIDTH_INSTR-1:0] exp_instr;
    logic [31:0]            exp_pc, exp_rd, exp_wd;
    logic [4:0]             exp_wa;
    logic [WIDTH_T-1:0]     exp_tnew;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("instr_WB", 32'(instr_WB), 32'(exp_instr));
            chk("PC_WB", PC_WB, exp_pc);
            chk("memReadData_WB", memReadData_WB, exp_rd);
            chk("regWriteAddr_WB", 32'(regWriteAddr_WB), 32'(exp_wa));
            chk("regWriteData_WB", regWriteData_WB, exp_wd);
            chk("Tnew_WB", 32'(Tnew_WB), 32'(exp_tnew));
        end
    end

    function automatic bit m_is_load(input logic [WIDTH_INSTR-1:0] i);
        return i == INSTR_LW || i == INSTR_LH || i == INSTR_LHU || i == INSTR_LB || i == INSTR_LBU;
    endfunction

    function automatic logic [31:0] m_load(input logic [WIDTH_INSTR-1:0] i, input int unsigned a);
        int unsigned w = a & ~32'd3;
        int unsigned hh = a & ~32'd1;
        logic [15:0] hv = {mb[hh + 1], mb[hh]};
        logic [7:0]  bv = mb[a];
        case (i)
            INSTR_LW:  return {mb[w + 3], mb[w + 2], mb[w + 1], mb[w]};
            INSTR_LH:  return 32'($signed(hv));
            INSTR_LHU: return {16'd0, hv};
            INSTR_LB:  return 32'($signed(bv));
            INSTR_LBU: return {24'd0, bv};
            default:   return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        int unsigned a = aluOut_MEM % 4096;
        logic [31:0] sd = (regaddr_WB != 0 && regaddr_WB == addrRt_MEM) ? regdata_WB : memWriteData_MEM;
        logic [31:0] ld = m_load(instr_MEM, a);
        if (reset) begin
            {exp_instr, exp_pc, exp_rd, exp_wa, exp_wd, exp_tnew} = '0;
            for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
        end else begin
            if (clr) begin
                {exp_instr, exp_pc, exp_rd, exp_wa, exp_wd, exp_tnew} = '0;
            end else if (!stall) begin
                exp_instr = instr_MEM;
                exp_pc    = PC_MEM;
                exp_rd    = ld;
                exp_wa    = regWriteAddr_MEM;
                exp_wd    = m_is_load(instr_MEM) ? ld : regWriteData_MEM;
                exp_tnew  = (Tnew_MEM == 0) ? '0 : Tnew_MEM - 1;
            end
            if (!stall) begin
                case (instr_MEM)
                    INSTR_SW: for (int k = 0; k < 4; k++) mb[(a & ~32'd3) + k] = sd[8*k +: 8];
                    INSTR_SH: for (int k = 0; k < 2; k++) mb[(a & ~32'd1) + k] = sd[8*k +: 8];
                    INSTR_SB: mb[a] = sd[7:0];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        chk_en = 1;
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic set_op(input logic [WIDTH_INSTR-1:0] ins, input logic [31:0] addr,
                          input logic [31:0] data);
        instr_MEM        = ins;
        aluOut_MEM       = addr;
        memWriteData_MEM = data;
        addrRt_MEM       = 5'd3;
        regaddr_WB       = 5'd0;
        regdata_WB       = $urandom;
        PC_MEM           = pc_ctr;
        pc_ctr           = pc_ctr + 4;
        regWriteAddr_MEM = 5'($urandom);
        regWriteData_MEM = $urandom;
        Tnew_MEM         = WIDTH_T'($urandom);
        stall            = 0;
        clr              = 0;
        reset            = 0;
    endtask

    task automatic op_chk(input logic [WIDTH_INSTR-1:0] ins, input logic [31:0] addr,
                          input string nm, input logic [31:0] req);
        set_op(ins, addr, 32'd0);
        cycle();
        chk(nm, regWriteData_WB, req);
    endtask

    localparam logic [WIDTH_INSTR-1:0] OPS [10] = '{INSTR_NOP, INSTR_ADD, INSTR_LW, INSTR_LH,
        INSTR_LHU, INSTR_LB, INSTR_LBU, INSTR_SW, INSTR_SH, INSTR_SB};

    initial begin
        set_op(INSTR_NOP, 0, 0);
        reset = 1;
        cycle();
        cycle();
        chk("reset regWriteData_WB", regWriteData_WB, 32'd0);
        chk("reset PC_WB", PC_WB, 32'd0);

        set_op(INSTR_SW, 32'h10, 32'h1234_5678); cycle();
        op_chk(INSTR_LW, 32'h10, "lw after sw", 32'h1234_5678);
        set_op(INSTR_SB, 32'h11, 32'h0000_00AB); cycle();
        op_chk(INSTR_LB, 32'h11, "lb sign", 32'hFFFF_FFAB);
        op_chk(INSTR_LBU, 32'h11, "lbu zero", 32'h0000_00AB);
        op_chk(INSTR_LW, 32'h10, "lw merged byte", 32'h1234_AB78);

        set_op(INSTR_SH, 32'h22, 32'h0000_8001); cycle();
        op_chk(INSTR_LH, 32'h22, "lh sign", 32'hFFFF_8001);
        op_chk(INSTR_LHU, 32'h22, "lhu zero", 32'h0000_8001);
        set_op(INSTR_SH, 32'h23, 32'h0000_7777); cycle();
        op_chk(INSTR_LW, 32'h20, "sh odd addr", 32'h7777_0000);

        set_op(INSTR_SW, 32'h30, 32'h1111);
        addrRt_MEM = 5'd5; regaddr_WB = 5'd5; regdata_WB = 32'h2222;
        cycle();
        op_chk(INSTR_LW, 32'h30, "fwd from wb", 32'h2222);
        set_op(INSTR_SW, 32'h34, 32'h1111);
        addrRt_MEM = 5'd5; regaddr_WB = 5'd0; regdata_WB = 32'h2222;
        cycle();
        op_chk(INSTR_LW, 32'h34, "no fwd r0", 32'h1111);

        op_chk(INSTR_LW, 32'h10, "pre-stall", 32'h1234_AB78);
        for (int s = 0; s < 3; s++) begin
            set_op(INSTR_SW, 32'h40, 32'hA000_0000 + s);
            stall = 1;
            cycle();
            chk("stall hold", regWriteData_WB, 32'h1234_AB78);
        end
        op_chk(INSTR_LW, 32'h40, "stall no write", 32'd0);
        set_op(INSTR_SW, 32'h44, 32'hEEEE); stall = 1; cycle();
        set_op(INSTR_SW, 32'h44, 32'hF00D); cycle();
        op_chk(INSTR_LW, 32'h44, "release write", 32'hF00D);

        set_op(INSTR_LW, 32'h10, 0); clr = 1; cycle();
        chk("clr bubble", regWriteData_WB, 32'd0);
        op_chk(INSTR_LW, 32'h10, "clr keeps mem", 32'h1234_AB78);
        set_op(INSTR_SW, 32'h48, 32'h5A5A); clr = 1; cycle();
        op_chk(INSTR_LW, 32'h48, "store under clr", 32'h5A5A);

        set_op(INSTR_SW, 32'h1000, 32'hDEAD); cycle();
        op_chk(INSTR_LW, 32'h0, "addr wrap", 32'hDEAD);
        set_op(INSTR_LW, 32'h0, 0); reset = 1; cycle();
        chk("reset outputs", regWriteData_WB, 32'd0);
        op_chk(INSTR_LW, 32'h0, "reset clears mem", 32'd0);

        for (int n = 0; n < 2000; n++) begin
            set_op(OPS[$urandom_range(0, 9)], 32'($urandom_range(0, 63)), $urandom);
            if ($urandom_range(0, 3) == 0) aluOut_MEM = aluOut_MEM | ($urandom & 32'hFFFF_F000);
            addrRt_MEM = 5'($urandom_range(0, 7));
            regaddr_WB = 5'($urandom_range(0, 7));
            stall      = ($urandom_range(0, 99) < 15);
            clr        = ($urandom_range(0, 99) < 8);
            reset      = ($urandom_range(0, 199) == 0);
            cycle();
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
